// File: rtl/pc_sequencer_if.sv
// Signal bundle between the PC sequencer and the fetch/decode/execute stages.
// The master side drives the request and pipeline inputs; the sequencer is the slave.
interface pc_sequencer_if;
  logic        start;
  logic [31:0] pc_in;
  logic [31:0] instr;
  logic        is_branch_taken;
  logic [31:0] branch_target;
  logic        stall_req;
  logic        pc_write;
  logic [31:0] next_pc;
  logic [2:0]  status;
  logic        halted;
  logic        fault;
  logic        timeout;
  logic [31:0] retired_count;
  logic [31:0] cycle_count;

  modport master (
    output start, pc_in, instr, is_branch_taken, branch_target, stall_req,
    input  pc_write, next_pc, status, halted, fault, timeout, retired_count, cycle_count
  );

  modport slave (
    input  start, pc_in, instr, is_branch_taken, branch_target, stall_req,
    output pc_write, next_pc, status, halted, fault, timeout, retired_count, cycle_count
  );
endinterface

// File: rtl/pc_sequencer.sv
// Boot/run/halt sequencer that decides when and where the PC register is written,
// with a run-cycle budget and sticky halt/fault/timeout end states.
//
// state   | meaning
// IDLE    | waiting for start after reset
// BOOT    | one cycle: load RESET_PC, clear counters
// RUN     | advancing PC; checks for halt, misaligned branch, cycle budget
// HALT    | halt instruction reached; PC held
// FAULT   | misaligned branch target; PC held
// TIMEOUT | run-cycle budget exhausted; PC held
module pc_sequencer #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] HALT_INSTR = 32'h0000_006F,
  parameter int unsigned MAX_CYCLES = 80
) (
  input logic          clk,
  input logic          reset,
  pc_sequencer_if.slave bus
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    BOOT    = 3'd1,
    RUN     = 3'd2,
    HALT    = 3'd3,
    FAULT   = 3'd4,
    TIMEOUT = 3'd5
  } state_t;

  localparam logic [31:0] LAST_CYCLE = 32'(MAX_CYCLES - 1);

  state_t      state_q, state_d;
  logic [31:0] cycle_q, retired_q;
  logic        halted_q, fault_q, timeout_q;
  logic        pc_write_d;
  logic [31:0] next_pc_d;
  logic        cycle_inc, retired_inc, count_clr;
  logic        misaligned, halt_hit;

  assign misaligned = bus.is_branch_taken && (bus.branch_target[1:0] != 2'b00);
  assign halt_hit   = (bus.instr == HALT_INSTR);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_write_d  = 1'b0;
    next_pc_d   = bus.pc_in;
    cycle_inc   = 1'b0;
    retired_inc = 1'b0;
    count_clr   = 1'b0;
    case (state_q)
      IDLE: begin
        next_pc_d = RESET_PC;
        if (bus.start) state_d = BOOT;
      end
      BOOT: begin
        pc_write_d = 1'b1;
        next_pc_d  = RESET_PC;
        count_clr  = 1'b1;
        state_d    = RUN;
      end
      RUN: begin
        cycle_inc = 1'b1;
        if (!bus.stall_req) begin
          // Fault outranks halt; a halt still counts as a retired instruction.
          if (misaligned) begin
            state_d = FAULT;
          end else if (halt_hit) begin
            retired_inc = 1'b1;
            state_d     = HALT;
          end else begin
            pc_write_d  = 1'b1;
            next_pc_d   = bus.is_branch_taken ? bus.branch_target : bus.pc_in + 32'd4;
            retired_inc = 1'b1;
          end
        end
        if (state_d == RUN && cycle_q == LAST_CYCLE) state_d = TIMEOUT;
      end
      HALT, FAULT, TIMEOUT: begin
        if (bus.start) state_d = BOOT;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cycle_q   <= '0;
      retired_q <= '0;
      halted_q  <= 1'b0;
      fault_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      if (count_clr) begin
        cycle_q   <= '0;
        retired_q <= '0;
      end else begin
        if (cycle_inc)   cycle_q   <= cycle_q + 32'd1;
        if (retired_inc) retired_q <= retired_q + 32'd1;
      end
      halted_q  <= (state_d == HALT);
      fault_q   <= (state_d == FAULT);
      timeout_q <= (state_d == TIMEOUT);
    end
  end

  assign bus.pc_write      = pc_write_d;
  assign bus.next_pc       = next_pc_d;
  assign bus.status        = state_q;
  assign bus.halted        = halted_q;
  assign bus.fault         = fault_q;
  assign bus.timeout       = timeout_q;
  assign bus.retired_count = retired_q;
  assign bus.cycle_count   = cycle_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed plus randomized bench for pc_sequencer, checked against a cycle-level
// reference model of the boot/run/end-state rules.
module tb_pc_sequencer;
  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam logic [31:0] HALT_INSTR = 32'h0000_006F;
  localparam int unsigned MAX_CYCLES = 80;
  localparam logic [31:0] NOP        = 32'h0000_0013;

  localparam int ST_IDLE = 0, ST_BOOT = 1, ST_RUN = 2, ST_HALT = 3, ST_FAULT = 4, ST_TIMEOUT = 5;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;

  int          m_mode;
  logic [31:0] m_cyc, m_ret;

  pc_sequencer_if bus ();

  pc_sequencer #(
    .RESET_PC  (RESET_PC),
    .HALT_INSTR(HALT_INSTR),
    .MAX_CYCLES(MAX_CYCLES)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_regs();
    chk("status",  32'(bus.status), 32'(m_mode));
    chk("halted",  32'(bus.halted), 32'(m_mode == ST_HALT));
    chk("fault",   32'(bus.fault), 32'(m_mode == ST_FAULT));
    chk("timeout", 32'(bus.timeout), 32'(m_mode == ST_TIMEOUT));
    chk("cycle_count",   bus.cycle_count, m_cyc);
    chk("retired_count", bus.retired_count, m_ret);
  endtask

  task automatic model_reset();
    m_mode = ST_IDLE;
    m_cyc  = '0;
    m_ret  = '0;
  endtask

  // One clock: check registered outputs, drive inputs, check the PC-write decision,
  // then advance the model across the rising edge.
  task automatic step(input logic st, input logic [31:0] pc, input logic [31:0] ins,
                      input logic br, input logic [31:0] tgt, input logic stl);
    logic        exp_pw;
    logic [31:0] exp_np;
    bit          np_known;
    bit          misal, last;
    @(negedge clk);
    check_regs();
    bus.start = st; bus.pc_in = pc; bus.instr = ins;
    bus.is_branch_taken = br; bus.branch_target = tgt; bus.stall_req = stl;
    misal    = br && (tgt[1:0] != 2'b00);
    exp_pw   = 1'b0;
    exp_np   = pc;
    np_known = 1;
    if (m_mode == ST_IDLE) exp_np = RESET_PC;
    else if (m_mode == ST_BOOT) begin
      exp_pw = 1'b1;
      exp_np = RESET_PC;
    end else if (m_mode == ST_RUN && !stl) begin
      if (misal || ins == HALT_INSTR) np_known = 0;
      else begin
        exp_pw = 1'b1;
        exp_np = br ? tgt : pc + 32'd4;
      end
    end
    #1;
    chk("pc_write", 32'(bus.pc_write), 32'(exp_pw));
    if (np_known) chk("next_pc", bus.next_pc, exp_np);
    @(posedge clk);
    case (m_mode)
      ST_IDLE: if (st) m_mode = ST_BOOT;
      ST_BOOT: begin
        m_cyc  = '0;
        m_ret  = '0;
        m_mode = ST_RUN;
      end
      ST_RUN: begin
        last  = (m_cyc == MAX_CYCLES - 1);
        m_cyc = m_cyc + 1;
        if (!stl && misal) m_mode = ST_FAULT;
        else if (!stl && ins == HALT_INSTR) begin
          m_ret  = m_ret + 1;
          m_mode = ST_HALT;
        end else begin
          if (!stl) m_ret = m_ret + 1;
          if (last) m_mode = ST_TIMEOUT;
        end
      end
      default: if (st) m_mode = ST_BOOT;
    endcase
  endtask

  task automatic boot();
    step(1'b1, 32'h0, NOP, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h0, NOP, 1'b0, 32'h0, 1'b0);
  endtask

  initial begin
    logic [31:0] pc;
    logic [31:0] ins, tgt;
    logic        br, stl, st;

    reset = 1'b0;
    bus.start = 0; bus.pc_in = 0; bus.instr = NOP;
    bus.is_branch_taken = 0; bus.branch_target = 0; bus.stall_req = 0;
    model_reset();
    #12;
    check_regs();
    chk("reset_pc_write", 32'(bus.pc_write), 32'd0);
    chk("reset_next_pc", bus.next_pc, RESET_PC);
    @(negedge clk) reset = 1'b1;

    for (int i = 0; i < 3; i++) step(1'b0, 32'h8, NOP, 1'b0, 32'h0, 1'b0);
    boot();
    #1 chk("boot_to_run", 32'(bus.status), ST_RUN);

    for (int i = 0; i < 3; i++) step(1'b0, 32'h10, NOP, 1'b0, 32'h0, 1'b0);
    #1 chk("seq_retired", bus.retired_count, 32'd3);
    step(1'b0, 32'h14, NOP, 1'b1, 32'h40, 1'b0);
    step(1'b0, 32'hFFFF_FFFC, NOP, 1'b0, 32'h0, 1'b0);
    step(1'b1, 32'h0, NOP, 1'b0, 32'h0, 1'b0);
    step(1'b0, 32'h24, HALT_INSTR, 1'b0, 32'h0, 1'b1);
    #1 chk("stalled_halt_ignored", 32'(bus.halted), 32'd0);
    step(1'b0, 32'h24, HALT_INSTR, 1'b0, 32'h0, 1'b0);
    #1 chk("halted_flag", 32'(bus.halted), 32'd1);
    step(1'b0, 32'h24, HALT_INSTR, 1'b0, 32'h0, 1'b0);

    boot();
    step(1'b0, 32'h30, NOP, 1'b1, 32'h42, 1'b0);
    #1 chk("misaligned_fault", 32'(bus.fault), 32'd1);

    boot();
    step(1'b0, 32'h30, HALT_INSTR, 1'b1, 32'h43, 1'b0);
    #1 chk("fault_beats_halt", 32'(bus.status), ST_FAULT);

    boot();
    pc = 32'h0;
    for (int i = 0; i < MAX_CYCLES; i++) begin
      stl = ($urandom_range(0, 3) == 0);
      step(1'b0, pc, NOP, 1'b0, 32'h0, stl);
      if (!stl) pc = pc + 4;
    end
    #1;
    chk("timeout_status", 32'(bus.status), ST_TIMEOUT);
    chk("timeout_cycles", bus.cycle_count, 32'd80);
    step(1'b0, pc, NOP, 1'b0, 32'h0, 1'b0);
    boot();
    #1 chk("reboot_cleared", bus.cycle_count, 32'd0);

    for (int i = 0; i < 600; i++) begin
      st  = ($urandom_range(0, 7) == 0);
      pc  = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      ins = ($urandom_range(0, 24) == 0) ? HALT_INSTR : ($urandom | 32'h8000_0000);
      br  = ($urandom_range(0, 3) == 0);
      tgt = {$urandom_range(0, 32'h3FFF_FFFF), 2'b00};
      if ($urandom_range(0, 9) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
      stl = ($urandom_range(0, 4) == 0);
      step(st, pc, ins, br, tgt, stl);
    end

    if (m_mode != ST_RUN) boot();
    step(1'b0, 32'h50, NOP, 1'b0, 32'h0, 1'b0);
    @(negedge clk);
    bus.start = 0; bus.pc_in = 32'h54; bus.instr = NOP;
    bus.is_branch_taken = 0; bus.stall_req = 0;
    #1 chk("pre_reset_pc_write", 32'(bus.pc_write), 32'd1);
    #1 reset = 1'b0;
    #1;
    model_reset();
    check_regs();
    chk("async_reset_pc_write", 32'(bus.pc_write), 32'd0);
    chk("async_reset_next_pc", bus.next_pc, RESET_PC);
    @(negedge clk) reset = 1'b1;
    for (int i = 0; i < 3; i++) step(1'b0, 32'h54, NOP, 1'b0, 32'h0, 1'b0);
    #1 chk("idle_after_reset", 32'(bus.status), ST_IDLE);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
